// File: rtl/csel_pkg.sv
// Shared defaults and elaboration-time helpers for the pipelined carry-select adder.
package csel_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int BLK_DEF   = 4;
    localparam int BPS_DEF   = 2;

    function automatic int nstg(input int width, input int blk, input int bps);
        return width / (blk * bps);
    endfunction

    // Bit offset of stage s's operand-skew register inside the packed skew vector.
    // Stage k carries width - (k+1)*sw unprocessed bits of B.
    function automatic int b_off(input int s, input int width, input int sw);
        return s * width - (sw * s * (s + 1)) / 2;
    endfunction

    function automatic bit params_legal(input int width, input int blk, input int bps);
        return (blk >= 2) && (bps >= 1) && (width > 0) && ((width % (blk * bps)) == 0);
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two ripple chains (carry-in 0 and 1) plus an output select.
// With FIRST set both chains take the true carry, so the block degenerates to a plain ripple adder.
module csel_block #(
    parameter int BLK   = 4,
    parameter bit FIRST = 1'b0
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin_sel,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [BLK:0]   k0;
    logic [BLK:0]   k1;
    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;

    always_comb begin
        k0    = '0;
        k1    = '0;
        s0    = '0;
        s1    = '0;
        k0[0] = FIRST ? cin_sel : 1'b0;
        k1[0] = FIRST ? cin_sel : 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ k0[i];
            k0[i+1] = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ k1[i];
            k1[i+1] = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
        end
    end

    assign s        = cin_sel ? s1 : s0;
    assign cout     = cin_sel ? k1[BLK] : k0[BLK];
    assign c_msb_in = cin_sel ? k1[BLK-1] : k0[BLK-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control and full backpressure.
// Each stage resolves BLK*BPS sum bits; unprocessed A bits share the stage register with the partial sum.
module csel_adder_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLK   = BLK_DEF,
    parameter int BPS   = BPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int SW   = BLK * BPS;
    localparam int NSTG = nstg(WIDTH, BLK, BPS);
    localparam int BW   = b_off(NSTG - 1, WIDTH, SW);
    localparam int BW_A = (BW > 0) ? BW : 1;

    if (!params_legal(WIDTH, BLK, BPS)) begin : g_bad_params
        $error("csel_adder_pipe: WIDTH must be a multiple of BLK*BPS and BLK must be >= 2");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  c_q;
    logic [NSTG-1:0]  en;
    logic [WIDTH-1:0] acc_q [NSTG];
    logic [BW_A-1:0]  b_pipe;
    logic             cm_q;

    assign b_eff   = in2 ^ {WIDTH{sub}};
    assign cin_eff = cin ^ sub;

    // Enables ripple back from the output so an empty stage always accepts.
    always_comb begin
        en         = '0;
        en[NSTG-1] = ~v_q[NSTG-1] | out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            en[k] = ~v_q[k] | en[k+1];
        end
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int LO   = s * SW;
        localparam int DONE = LO + SW;
        localparam int RB   = WIDTH - DONE;
        localparam int BIN  = (s == 0) ? 0 : b_off(s - 1, WIDTH, SW);
        localparam int BOUT = b_off(s, WIDTH, SW);

        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] acc_nxt;
        logic [WIDTH-1:0] acc_r;
        logic [SW-1:0]    a_cur;
        logic [SW-1:0]    b_cur;
        logic [SW-1:0]    s_cur;
        logic [BPS:0]     kc;
        logic [BPS-1:0]   km;
        logic             c_in;
        logic             v_up;
        logic             v_r;
        logic             c_r;
        logic             unused_km;

        if (s == 0) begin : g_src
            assign acc_in = in1;
            assign b_cur  = b_eff[SW-1:0];
            assign c_in   = cin_eff;
            assign v_up   = in_valid;
        end else begin : g_src
            assign acc_in = acc_q[s-1];
            assign b_cur  = b_pipe[BIN +: SW];
            assign c_in   = c_q[s-1];
            assign v_up   = v_q[s-1];
        end

        assign a_cur = acc_in[LO +: SW];
        assign kc[0] = c_in;

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            csel_block #(
                .BLK   (BLK),
                .FIRST ((s == 0) && (j == 0))
            ) u_blk (
                .a        (a_cur[j*BLK +: BLK]),
                .b        (b_cur[j*BLK +: BLK]),
                .cin_sel  (kc[j]),
                .s        (s_cur[j*BLK +: BLK]),
                .cout     (kc[j+1]),
                .c_msb_in (km[j])
            );
        end

        // Only the very top block's carry-into-MSB feeds overflow.
        assign unused_km = ^km;

        always_comb begin
            acc_nxt           = acc_in;
            acc_nxt[LO +: SW] = s_cur;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                acc_r <= '0;
                c_r   <= 1'b0;
            end else begin
                if (en[s]) begin
                    v_r <= v_up;
                end
                if (en[s] && v_up) begin
                    acc_r <= acc_nxt;
                    c_r   <= kc[BPS];
                end
            end
        end

        assign v_q[s]   = v_r;
        assign c_q[s]   = c_r;
        assign acc_q[s] = acc_r;

        if (s < NSTG - 1) begin : g_skew
            logic [RB-1:0] b_nxt;
            logic [RB-1:0] b_r;

            if (s == 0) begin : g_bsrc
                assign b_nxt = b_eff[WIDTH-1:SW];
            end else begin : g_bsrc
                assign b_nxt = b_pipe[BIN + SW +: RB];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b_r <= '0;
                end else if (en[s] && v_up) begin
                    b_r <= b_nxt;
                end
            end

            assign b_pipe[BOUT +: RB] = b_r;
        end

        if (s == NSTG - 1) begin : g_ovf
            logic cm_r;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cm_r <= 1'b0;
                end else if (en[s] && v_up) begin
                    cm_r <= km[BPS-1];
                end
            end

            assign cm_q = cm_r;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[NSTG-1];
    assign sum       = acc_q[NSTG-1];
    assign carryout  = c_q[NSTG-1];
    assign overflow  = cm_q ^ c_q[NSTG-1];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed corner cases, backpressure, mid-stream reset and random
// traffic scored in order against an arithmetic model of add/subtract.
module tb_csel_adder_pipe;

    localparam int WIDTH = 32;
    localparam int BLK   = 4;
    localparam int BPS   = 2;
    localparam int NSTG  = WIDTH / (BLK * BPS);

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    logic hold_pend = 1'b0;
    res_t hold_val;

    csel_adder_pipe #(
        .WIDTH (WIDTH),
        .BLK   (BLK),
        .BPS   (BPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/carry, signed result for overflow.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        longint ua, ub, sa, sbv, c, ures, sres;
        res_t   r;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        c   = ci ? 64'sd1 : 64'sd0;
        if (!sb) begin
            ures = ua + ub + c;
            sres = sa + sbv + c;
            r.co = (ures >= 64'sh1_0000_0000);
        end else begin
            ures = ua - ub - c;
            sres = sa - sbv - c;
            r.co = (ua >= ub + c);
        end
        r.s  = ures[31:0];
        r.ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // In-order scoreboard plus hold-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {sum, carryout, overflow}, hold_val);
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {sum, carryout, overflow};
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk("result", {sum, carryout, overflow}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in1, in2, cin, sub));
            end
        end
    end

    task automatic dir_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          input logic [31:0] es, input logic eco, input logic eov);
        @(posedge clk); #1;
        in1       = a;
        in2       = b;
        cin       = ci;
        sub       = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({tag, "_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NSTG - 2) @(posedge clk);
        #1 chk({tag, "_early"}, out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, carryout, eco);
        chk({tag, "_ovf"}, overflow, eov);
    endtask

    task automatic drain(input string tag);
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int   sent, cyc, ghost, out_base;
        logic fire, saw_full;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", carryout, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Directed corners
        dir_op("inc",      32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        dir_op("chain",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir_op("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir_op("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        dir_op("sub_brw",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        dir_op("neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        drain("dir_drain");

        // Backpressure: 10 back-to-back ops, consumer stalls for 6 cycles mid-stream
        out_base = n_out;
        sent     = 0;
        cyc      = 0;
        saw_full = 1'b0;
        while (sent < 10 && cyc < 200) begin
            in1       = $urandom;
            in2       = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            out_ready = !(cyc >= 3 && cyc < 9);
            @(negedge clk);
            fire = in_ready;
            if (!in_ready) saw_full = 1'b1;
            @(posedge clk); #1;
            if (fire) sent++;
            cyc++;
        end
        chk("bp_sent", sent, 10);
        chk("bp_full", saw_full, 1'b1);
        drain("bp_drain");
        chk("bp_count", n_out - out_base, 10);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in1      = 32'h0000_0100 + 32'(k);
            in2      = 32'h0000_0011;
            cin      = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", sum, 32'h0);
        chk("mid_rst_cout", carryout, 1'b0);
        rst_n = 1'b1;
        #1 chk("mid_rst_ready", in_ready, 1'b1);
        ghost = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) ghost++;
        end
        chk("mid_rst_ghost", ghost, 0);

        // Random traffic with random stalls
        for (int i = 0; i < 3000; i++) begin
            in1       = pick();
            in2       = pick();
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
